// File: rtl/uart_rx_deframer_if.sv
// Byte stream and error pulses from the UART receive front end to the command FSM.
// The master is the deframer. The slave is the consumer that drives rx_ready.
interface uart_rx_deframer_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       framing_err;
   logic       overrun_err;

   modport master (
      output rx_valid, rx_data, framing_err, overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_valid, rx_data, framing_err, overrun_err,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises uart_rxd, recovers frames and holds one byte
// on a valid/ready stream. Framing and overrun errors are reported as 1-cycle pulses.
module uart_rx_deframer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                clk,
   input  logic                m_aresetn,
   input  logic                uart_rxd,
   uart_rx_deframer_if.master  rx_if
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   // The counter restarts at 0 on the cycle after each decision, so a decision
   // that is N cycles later fires when the counter reads N-1.
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             shift_q, shift_d;
   logic                   valid_q, valid_d;
   logic [7:0]             data_q, data_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      valid_d = valid_q;
      data_d  = data_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && rx_if.rx_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rxd_s) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rxd_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rxd_s) begin
                  // Returning to IDLE at mid-stop leaves half a bit to catch the next start.
                  state_d = IDLE;
                  if (!valid_q || rx_if.rx_ready) begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxd_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_if.rx_valid    = valid_q;
   assign rx_if.rx_data     = data_q;
   assign rx_if.framing_err = ferr_q;
   assign rx_if.overrun_err = ovr_q;

endmodule
